// File: rtl/matvec_pkg.sv
// Shared constants and FSM state type for the matvec engine stream driver.
package matvec_pkg;

    localparam int DATA_W = 14;
    localparam int RES_W  = 28;
    localparam int NUM_W  = 9;
    localparam int NUM_X  = 3;
    localparam int X_BASE = NUM_W;
    localparam int NUM_ELEM = X_BASE + NUM_X;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RECV,
        ST_DONE
    } state_t;

endpackage

// File: rtl/matvec_stream_driver_counter.sv
// Up-counter with synchronous clear; clear wins over increment.
module matvec_stream_driver_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/matvec_stream_driver.sv
// Serialises a 3x3 matrix and 3-vector to the matvec engine, then captures its
// three results for host readback.
module matvec_stream_driver
    import matvec_pkg::*;
#(
    parameter int DATA_W = matvec_pkg::DATA_W,
    parameter int RES_W  = matvec_pkg::RES_W,
    parameter int NUM_W  = matvec_pkg::NUM_W,
    parameter int NUM_X  = matvec_pkg::NUM_X
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_wr_en,
    input  logic [3:0]               cfg_wr_addr,
    input  logic signed [DATA_W-1:0] cfg_wr_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic signed [DATA_W-1:0] tx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    input  logic signed [RES_W-1:0]  rx_data,
    input  logic [1:0]               res_addr,
    output logic signed [RES_W-1:0]  res_data
);

    localparam int N_ELEM  = NUM_W + NUM_X;
    localparam int SEND_CW = $clog2(N_ELEM);
    localparam int RECV_CW = $clog2(NUM_X);

    state_t                   state;
    logic signed [DATA_W-1:0] elem   [N_ELEM];
    logic signed [RES_W-1:0]  result [NUM_X];

    logic [SEND_CW-1:0] send_cnt;
    logic [SEND_CW-1:0] send_nxt;
    logic [RECV_CW-1:0] recv_cnt;
    logic tx_fire, rx_fire, last_send, last_recv, send_clr, recv_clr;

    assign tx_fire   = tx_valid & tx_ready;
    assign rx_fire   = rx_valid & rx_ready;
    assign last_send = (send_cnt == SEND_CW'(N_ELEM - 1));
    assign last_recv = (recv_cnt == RECV_CW'(NUM_X - 1));
    assign send_nxt  = send_cnt + SEND_CW'(1);
    assign send_clr  = (state == ST_IDLE) && start;
    assign recv_clr  = tx_fire && last_send;

    matvec_stream_driver_counter #(.WIDTH(SEND_CW)) u_send_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (send_clr),
        .inc   (tx_fire),
        .count (send_cnt)
    );

    matvec_stream_driver_counter #(.WIDTH(RECV_CW)) u_recv_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (recv_clr),
        .inc   (rx_fire),
        .count (recv_cnt)
    );

    // tx_data is registered one element ahead so it is stable across stalls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_valid <= 1'b0;
            rx_ready <= 1'b0;
            tx_data  <= '0;
            for (int unsigned i = 0; i < N_ELEM; i++) elem[SEND_CW'(i)] <= '0;
            for (int unsigned i = 0; i < NUM_X; i++) result[RECV_CW'(i)] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cfg_wr_en && (cfg_wr_addr < 4'(N_ELEM))) begin
                        elem[cfg_wr_addr] <= cfg_wr_data;
                    end
                    if (start) begin
                        state    <= ST_SEND;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                        tx_data  <= elem[0];
                    end
                end
                ST_SEND: begin
                    if (tx_fire) begin
                        if (last_send) begin
                            state    <= ST_RECV;
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            rx_ready <= 1'b1;
                        end else begin
                            tx_data <= elem[send_nxt];
                        end
                    end
                end
                ST_RECV: begin
                    if (rx_fire) begin
                        result[recv_cnt] <= rx_data;
                        if (last_recv) begin
                            state    <= ST_DONE;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        res_data = '0;
        if (res_addr < 2'(NUM_X)) res_data = result[res_addr];
    end

endmodule
